insn_fetch: RTL and testbench

Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register. It owns the fetch program counter and issues one-outstanding-request reads to the instruction memory bus. It presents the returned word with its address to the IF/ID register, and raises `busy` to stall the pipeline while a fetch is in flight. Branch and flush redirects are accepted at any time; responses to requests made before a redirect are discarded.

---
 rtl/insn_fetch_pkg.sv | 20 ++
 rtl/insn_fetch.sv | 104 ++++++++++
 tb/tb_insn_fetch.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/insn_fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM state codes,
// the architectural NOP word and the enable polarity constants.
package insn_fetch_pkg;

  typedef enum logic [2:0] {
    IF_ST_IDLE = 3'd0,
    IF_ST_REQ  = 3'd1,
    IF_ST_WAIT = 3'd2,
    IF_ST_HOLD = 3'd3,
    IF_ST_DROP = 3'd4
  } if_state_e;

  localparam logic [31:0] ISA_NOP = 32'h0000_0013;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;
  // Asserted level of an active-low control.
  localparam logic ENABLE_ = 1'b0;

endpackage

// File: rtl/insn_fetch.sv
// Instruction-fetch front end: owns the fetch PC, issues one outstanding
// imem read at a time and discards responses made stale by a redirect.
module insn_fetch
  import insn_fetch_pkg::*;
#(
  parameter logic [29:0] RESET_PC = 30'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [29:0] new_pc,
  input  logic        br_taken,
  input  logic [29:0] br_addr,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rdy,
  input  logic [31:0] imem_rd_data,
  output logic [29:0] fetch_pc,
  output logic [31:0] insn,
  output logic        insn_valid,
  output logic        busy
);

  if_state_e   state_q, state_d;
  logic [29:0] pc_q, pc_d;
  logic [29:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] insn_q, insn_d;
  logic        insn_valid_q, insn_valid_d;

  logic        redirect;
  logic [29:0] target;

  assign redirect = flush | br_taken;
  assign target   = flush ? new_pc : br_addr;

  always_ff @(posedge clk) begin
    if (reset == ENABLE_) begin
      state_q      <= IF_ST_IDLE;
      pc_q         <= RESET_PC;
      fetch_pc_q   <= RESET_PC;
      insn_q       <= ISA_NOP;
      insn_valid_q <= DISABLE;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_pc_q   <= fetch_pc_d;
      insn_q       <= insn_d;
      insn_valid_q <= insn_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = redirect ? target : pc_q;
    fetch_pc_d   = fetch_pc_q;
    insn_d       = insn_q;
    insn_valid_d = insn_valid_q;

    unique case (state_q)
      IF_ST_IDLE: state_d = IF_ST_REQ;
      IF_ST_REQ: begin
        // A grant in the redirect cycle means the old address already left.
        if (imem_gnt) state_d = redirect ? IF_ST_DROP : IF_ST_WAIT;
      end
      IF_ST_WAIT: begin
        if (imem_rdy) begin
          if (redirect) begin
            state_d = IF_ST_REQ;
          end else begin
            state_d      = IF_ST_HOLD;
            insn_d       = imem_rd_data;
            insn_valid_d = ENABLE;
            fetch_pc_d   = pc_q;
          end
        end else if (redirect) begin
          state_d = IF_ST_DROP;
        end
      end
      IF_ST_HOLD: begin
        if (redirect || !stall) begin
          state_d      = IF_ST_REQ;
          insn_d       = ISA_NOP;
          insn_valid_d = DISABLE;
          if (!redirect) pc_d = pc_q + 30'd1;
        end
      end
      IF_ST_DROP: begin
        if (imem_rdy) state_d = IF_ST_REQ;
      end
      default: state_d = IF_ST_IDLE;
    endcase
  end

  assign imem_req   = (state_q == IF_ST_REQ);
  assign busy       = (state_q == IF_ST_REQ) || (state_q == IF_ST_WAIT) ||
                      (state_q == IF_ST_DROP);
  assign imem_addr  = pc_q;
  assign fetch_pc   = fetch_pc_q;
  assign insn       = insn_q;
  assign insn_valid = insn_valid_q;

endmodule

// File: tb/tb_insn_fetch.sv
// Bench for insn_fetch: transaction-level reference model plus memory
// responder, directed scenarios and a randomized soak.
module tb_insn_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall, flush, br_taken;
  logic [29:0] new_pc, br_addr;
  logic        imem_req, imem_gnt, imem_rdy;
  logic [29:0] imem_addr, fetch_pc;
  logic [31:0] imem_rd_data, insn;
  logic        insn_valid, busy;

  insn_fetch #(.RESET_PC(30'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .new_pc(new_pc),
    .br_taken(br_taken), .br_addr(br_addr), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rdy(imem_rdy),
    .imem_rd_data(imem_rd_data), .fetch_pc(fetch_pc), .insn(insn),
    .insn_valid(insn_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: one flag per phase of a fetch transaction.
  bit          m_known = 0;
  bit          m_idle, m_req, m_out, m_stale, m_valid;
  logic [29:0] m_pc, m_fpc;
  logic [31:0] m_insn;

  always @(posedge clk) begin
    bit          redir;
    logic [29:0] tgt;
    if (reset === 1'b0) begin
      m_known = 1; m_idle = 1; m_req = 0; m_out = 0; m_stale = 0; m_valid = 0;
      m_pc = 30'h0; m_fpc = 30'h0; m_insn = NOP;
    end else if (m_known) begin
      redir = flush | br_taken;
      tgt   = flush ? new_pc : br_addr;
      if (m_idle) begin
        m_idle = 0; m_req = 1;
      end else if (m_req) begin
        if (imem_gnt) begin m_req = 0; m_out = 1; m_stale = redir; end
      end else if (m_out) begin
        if (imem_rdy) begin
          m_out = 0;
          if (m_stale || redir) m_req = 1;
          else begin m_valid = 1; m_insn = imem_rd_data; m_fpc = m_pc; end
        end else if (redir) m_stale = 1;
      end else if (redir || !stall) begin
        m_valid = 0; m_insn = NOP; m_req = 1;
        if (!redir) m_pc = m_pc + 30'd1;
      end
      if (redir) m_pc = tgt;
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      check("imem_req",   imem_req,   m_req);
      check("busy",       busy,       m_req | m_out);
      check("imem_addr",  imem_addr,  m_pc);
      check("insn_valid", insn_valid, m_valid);
      check("fetch_pc",   fetch_pc,   m_fpc);
      check("insn",       insn,       m_insn);
    end
  end

  // Memory responder: single outstanding read, data = A0000000 + address.
  bit          rand_mode = 0;
  int unsigned fixed_lat = 0;
  bit          mem_out = 0;
  int unsigned mem_cnt = 0;
  logic [29:0] mem_addr = '0;

  task automatic cyc();
    @(posedge clk);
    #1;
    imem_rdy     = 1'b0;
    imem_rd_data = $urandom;
    if (mem_out) begin
      if (mem_cnt == 0) begin
        imem_rdy     = 1'b1;
        imem_rd_data = 32'hA000_0000 + {2'b00, mem_addr};
        mem_out      = 0;
      end else mem_cnt--;
    end else if (rand_mode && $urandom_range(4) == 0) imem_rdy = 1'b1;
    imem_gnt = 1'b0;
    if (reset && imem_req && !mem_out && (!rand_mode || $urandom_range(2) != 0)) begin
      imem_gnt = 1'b1;
      mem_out  = 1;
      mem_addr = imem_addr;
      mem_cnt  = rand_mode ? $urandom_range(3) : fixed_lat;
    end else if (rand_mode && !imem_req && $urandom_range(3) == 0) imem_gnt = 1'b1;
  endtask

  initial begin
    bit          found;
    logic [29:0] hold_pc;
    logic [31:0] hold_insn;
    reset = 0; stall = 0; flush = 0; br_taken = 0; new_pc = '0; br_addr = '0;
    imem_gnt = 0; imem_rdy = 0; imem_rd_data = '0;
    repeat (2) cyc();
    check("reset_valid", insn_valid, 1'b0);
    check("reset_busy",  busy,       1'b0);
    check("reset_req",   imem_req,   1'b0);
    reset = 1;

    // Zero-wait streaming: REQ, WAIT, HOLD per instruction.
    for (int unsigned k = 1; k <= 9; k++) begin
      cyc();
      if (k % 3 == 1) begin
        check("seq_req", imem_req, 1'b1);
        check("seq_addr", imem_addr, (k - 1) / 3);
      end else if (k % 3 == 0) begin
        check("seq_valid", insn_valid, 1'b1);
        check("seq_fpc", fetch_pc, k / 3 - 1);
        check("seq_insn", insn, 32'hA000_0000 + k / 3 - 1);
      end else check("seq_novalid", insn_valid, 1'b0);
    end

    // Stall in HOLD.
    stall = 1; hold_pc = fetch_pc; hold_insn = insn;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("stall_valid", insn_valid, 1'b1);
      check("stall_fpc", fetch_pc, hold_pc);
      check("stall_insn", insn, hold_insn);
      check("stall_req", imem_req, 1'b0);
    end
    stall = 0;
    cyc();
    check("post_stall_addr", imem_addr, hold_pc + 30'd1);

    // Branch in the same cycle as the grant for address 5.
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (imem_req && imem_addr == 30'd5) found = 1; else cyc();
    end
    check("find_addr5", found, 1'b1);
    br_taken = 1; br_addr = 30'h100;
    cyc();
    br_taken = 0;
    check("drop_busy", busy, 1'b1);
    check("drop_req", imem_req, 1'b0);
    cyc();
    check("br_req", imem_req, 1'b1);
    check("br_addr", imem_addr, 30'h100);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin cyc(); found = insn_valid; end
    check("br_found", found, 1'b1);
    check("br_fpc", fetch_pc, 30'h100);
    check("br_insn", insn, 32'hA000_0100);

    // Flush beats branch while in HOLD.
    flush = 1; new_pc = 30'h40; br_taken = 1; br_addr = 30'h80;
    cyc();
    flush = 0; br_taken = 0;
    check("flush_valid", insn_valid, 1'b0);
    check("flush_insn", insn, NOP);
    check("flush_addr", imem_addr, 30'h40);

    // PC wrap.
    flush = 1; new_pc = 30'h3FFF_FFFF;
    cyc();
    flush = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin cyc(); found = insn_valid; end
    check("wrap_found", found, 1'b1);
    check("wrap_fpc", fetch_pc, 30'h3FFF_FFFF);
    cyc();
    check("wrap_addr", imem_addr, 30'h0);

    // Reset during WAIT with a slow memory; late data must be dropped.
    fixed_lat = 3;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      cyc();
      found = busy && !imem_req && mem_out;
    end
    check("find_wait", found, 1'b1);
    reset = 0;
    cyc();
    reset = 1;
    check("rst_busy", busy, 1'b0);
    check("rst_fpc", fetch_pc, 30'h0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin cyc(); found = insn_valid; end
    check("rst_found", found, 1'b1);
    check("rst_fpc2", fetch_pc, 30'h0);
    check("rst_insn", insn, 32'hA000_0000);

    // Randomized soak.
    rand_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      reset    = 1;
      stall    = ($urandom_range(2) == 0);
      flush    = ($urandom_range(15) == 0);
      br_taken = ($urandom_range(11) == 0);
      new_pc   = ($urandom_range(3) == 0) ? 30'h3FFF_FFFE : 30'($urandom);
      br_addr  = 30'($urandom_range(255));
      if ($urandom_range(199) == 0) begin
        reset = 0;
        if (imem_gnt && imem_req) mem_out = 0;
        imem_gnt = 0;
      end
    end
    reset = 1; flush = 0; br_taken = 0;
    cyc();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
